prog_loader: RTL and testbench

- Front-end sequencer directly upstream of the two-phase MIPS32 pipeline (`processor`).
- Streams a program/data image into the processor's unified memory through a valid/ready word interface.
- Releases the processor to run from pc=0, then watches for HLT or a watchdog timeout.
- Replaces hierarchical memory pokes and fixed delays in benches and system bring-up.

---
 rtl/prog_loader.sv | 90 +++++++++
 tb/tb_prog_loader.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// prog_loader: streams a word image into processor memory, releases the cpu from pc=0, then waits for HLT or the watchdog
//   clk1, rst_n          clock, async active-low reset
//   start, abort         sequence control (abort wins)
//   load_base/load_count image placement, latched on start
//   s_valid/s_data/s_ready  word stream handshake
//   mem_we/addr/wdata    registered memory write port
//   cpu_run, cpu_halted  processor release level and halt flag
//   busy, done, timeout, run_cycles  status
module prog_loader #(
  parameter int ADDR_W  = 10,
  parameter int CNT_W   = 11,
  parameter int CYC_W   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  input  logic              cpu_halted,
  output logic              busy,
  output logic              done,
  output logic              timeout,
  output logic [CYC_W-1:0]  run_cycles
);
  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0] count, idx;
  logic hs, go, last, halt_q, wd;
  assign hs = s_valid && state == LOAD && !abort;
  assign go = (state == IDLE || state == DONE) && start && !abort;
  assign last = idx == count - CNT_W'(1);
  // run_cycles still holds the previous count during a RUN cycle, so zero marks the first cycle
  assign halt_q = cpu_halted && run_cycles != '0;
  assign wd = run_cycles == CYC_W'(TIMEOUT - 1);
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb begin
    s_ready = state == LOAD && !abort;
    cpu_run = state == RUN;
    busy = state == LOAD || state == SETTLE || state == RUN;
    done = state == DONE;
    nxt = abort ? IDLE :
          go ? (load_count != '0 ? LOAD : SETTLE) :
          state == LOAD ? (hs && last ? SETTLE : LOAD) :
          state == SETTLE ? RUN :
          state == RUN ? (halt_q || wd ? DONE : RUN) :
          state;
  end
  always_ff @(posedge clk1 or negedge rst_n)
    if (!rst_n) begin
      base <= '0;
      count <= '0;
      idx <= '0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      run_cycles <= '0;
      timeout <= 1'b0;
    end else begin
      mem_we <= hs;
      if (hs) begin
        mem_addr <= base + ADDR_W'(idx);
        mem_wdata <= s_data;
        idx <= idx + CNT_W'(1);
      end
      if (go) begin
        base <= load_base;
        count <= load_count;
        idx <= '0;
        run_cycles <= '0;
        timeout <= 1'b0;
      end
      // a halt in the same cycle as the watchdog wins
      if (state == RUN && !abort) begin
        run_cycles <= run_cycles + CYC_W'(1);
        timeout <= wd && !halt_q;
      end
    end
endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader with a per-cycle reference model
module tb_prog_loader;
  localparam int AW = 10, CW = 11, YW = 16, TO = 64;
  localparam int M_IDLE = 0, M_LOAD = 1, M_SET = 2, M_RUN = 3, M_DONE = 4;
  logic clk1 = 0, rst_n = 0, start = 0, abort = 0, s_valid = 0, cpu_halted = 0;
  logic [AW-1:0] load_base = '0;
  logic [CW-1:0] load_count = '0;
  logic [31:0] s_data = '0;
  logic s_ready, mem_we, cpu_run, busy, done, timeout;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [YW-1:0] run_cycles;
  prog_loader #(.ADDR_W(AW), .CNT_W(CW), .CYC_W(YW), .TIMEOUT(TO)) dut (
    .clk1(clk1), .rst_n(rst_n), .start(start), .abort(abort),
    .load_base(load_base), .load_count(load_count),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_run(cpu_run), .cpu_halted(cpu_halted),
    .busy(busy), .done(done), .timeout(timeout), .run_cycles(run_cycles)
  );
  always #5 clk1 = ~clk1;
  int total = 0, bad = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask
  int ph, m_base, m_cnt, m_idx, m_rc, m_addr;
  bit m_to, m_we;
  logic [31:0] m_data;
  always @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      ph = M_IDLE; m_base = 0; m_cnt = 0; m_idx = 0; m_rc = 0;
      m_to = 0; m_we = 0; m_addr = 0; m_data = 0;
    end else begin
      m_we = s_valid && ph == M_LOAD && !abort;
      if (m_we) begin
        m_addr = (m_base + m_idx) % (1 << AW);
        m_data = s_data;
        m_idx++;
      end
      if (abort) ph = M_IDLE;
      else if ((ph == M_IDLE || ph == M_DONE) && start) begin
        m_base = load_base; m_cnt = load_count; m_idx = 0; m_rc = 0; m_to = 0;
        ph = m_cnt != 0 ? M_LOAD : M_SET;
      end else if (ph == M_LOAD && m_idx == m_cnt) ph = M_SET;
      else if (ph == M_SET) ph = M_RUN;
      else if (ph == M_RUN) begin
        m_rc++;
        if (cpu_halted && m_rc > 1) ph = M_DONE;
        else if (m_rc == TO) begin ph = M_DONE; m_to = 1; end
      end
    end
  end
  always @(negedge clk1) if (rst_n) begin
    chk("s_ready", s_ready, ph == M_LOAD && !abort);
    chk("mem_we", mem_we, m_we);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_wdata", mem_wdata, m_data);
    chk("cpu_run", cpu_run, ph == M_RUN);
    chk("busy", busy, ph == M_LOAD || ph == M_SET || ph == M_RUN);
    chk("done", done, ph == M_DONE);
    chk("timeout", timeout, m_to);
    chk("run_cycles", run_cycles, m_rc);
  end
  int rdy_n = 0;
  logic [AW-1:0] cap_a[$];
  logic [31:0] cap_d[$];
  always @(negedge clk1) if (rst_n) begin
    if (s_ready) rdy_n++;
    if (mem_we) begin
      cap_a.push_back(mem_addr);
      cap_d.push_back(mem_wdata);
    end
  end
  int rn = 0, halt_at = 0;
  bit early = 0;
  always @(posedge clk1) begin
    #1;
    rn = cpu_run ? rn + 1 : 0;
    cpu_halted = rn != 0 && (rn == halt_at || (early && rn == 1));
  end
  task automatic tick();
    @(posedge clk1);
    #2;
  endtask
  task automatic clr();
    rdy_n = 0;
    cap_a.delete();
    cap_d.delete();
  endtask
  task automatic go(input int b, input int c);
    load_base = AW'(b);
    load_count = CW'(c);
    start = 1;
    tick();
    start = 0;
  endtask
  task automatic load_words(input int n, input logic [31:0] pat, input int plen, input logic [31:0] seed);
    int k = 0;
    bit h;
    for (int j = 0; j < 200 && k < n; j++) begin
      s_valid = (j < plen) ? pat[j] : 1'b1;
      s_data = seed + k;
      @(negedge clk1);
      h = s_valid && s_ready;
      tick();
      if (h) k++;
    end
    s_valid = 0;
    chk("words_loaded", k, n);
  endtask
  task automatic wait_done(input int budget);
    int i = 0;
    while (!done && i < budget) begin
      tick();
      i++;
    end
    chk("done_reached", done, 1);
  endtask
  logic [AW-1:0] wexp[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
  initial begin
    #1;
    chk("rst_cpu_run", cpu_run, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_done", done, 0);
    chk("rst_run_cycles", run_cycles, 0);
    chk("rst_s_ready", s_ready, 0);
    #20 rst_n = 1;
    tick();
    clr(); halt_at = 40;
    go(0, 13);
    load_words(13, 0, 0, 32'hF00D_0000);
    wait_done(100);
    chk("fact_run_cycles", run_cycles, 40);
    chk("fact_timeout", timeout, 0);
    chk("fact_nwrites", cap_a.size(), 13);
    chk("fact_ready_cycles", rdy_n, 13);
    for (int i = 0; i < 13 && i < cap_a.size(); i++) begin
      chk("fact_addr", cap_a[i], i);
      chk("fact_data", cap_d[i], 32'hF00D_0000 + i);
    end
    halt_at = 0;
    clr(); halt_at = 5;
    go(100, 4);
    load_words(4, 32'b1011001, 7, 32'hB000);
    wait_done(100);
    chk("bp_nwrites", cap_a.size(), 4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) begin
      chk("bp_addr", cap_a[i], 100 + i);
      chk("bp_data", cap_d[i], 32'hB000 + i);
    end
    chk("bp_run_cycles", run_cycles, 5);
    clr(); halt_at = 3;
    go(1022, 4);
    load_words(4, 0, 0, 32'hC000);
    wait_done(100);
    chk("wrap_nwrites", cap_a.size(), 4);
    for (int i = 0; i < 4 && i < cap_a.size(); i++) chk("wrap_addr", cap_a[i], wexp[i]);
    clr(); halt_at = 0; early = 1;
    go(0, 0);
    repeat (10) tick();
    chk("wd_running", cpu_run, 1);
    load_base = 5; load_count = 7; start = 1;
    tick();
    start = 0;
    wait_done(200);
    early = 0;
    chk("wd_run_cycles", run_cycles, 64);
    chk("wd_timeout", timeout, 1);
    chk("wd_nwrites", cap_a.size(), 0);
    clr();
    go(200, 8);
    load_words(3, 0, 0, 32'hD000);
    s_valid = 1; s_data = 32'hD003; abort = 1;
    tick();
    abort = 0; s_valid = 0;
    repeat (3) tick();
    chk("abort_nwrites", cap_a.size(), 3);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    go(0, 0);
    repeat (5) tick();
    chk("arst_pre_run", cpu_run, 1);
    rst_n = 0;
    #1;
    chk("arst_cpu_run", cpu_run, 0);
    chk("arst_busy", busy, 0);
    chk("arst_run_cycles", run_cycles, 0);
    #10 rst_n = 1;
    tick();
    chk("arst_idle_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "bench timed out");
  end
endmodule
